// File: rtl/region_pkg.sv
// Shared definitions for the region-boundary loader.
// Contents: region point count and sync bytes, region index and error-code
// encodings, the RAM word and address widths, the parser state encoding and
// the internal write-request record that the parser passes to the write demux.
package region_pkg;

    localparam int unsigned NUM_POINTS = 811;
    localparam logic [7:0]  HDR0       = 8'hA5;
    localparam logic [7:0]  HDR1       = 8'h5A;

    localparam int RAM_DW = 18;
    localparam int RAM_AW = 10;

    typedef enum logic [1:0] {
        REGION_INNER  = 2'd0,
        REGION_MIDDLE = 2'd1,
        REGION_OUTER  = 2'd2
    } region_sel_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_HDR  = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_SEL,
        S_ST_H,
        S_ST_L,
        S_CN_H,
        S_CN_L,
        S_D_H,
        S_D_L,
        S_CHK
    } state_t;

    // One RAM write request, produced combinationally on D_L acceptance.
    typedef struct packed {
        logic              en;
        region_sel_t       sel;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
    } ram_wr_t;

endpackage

// File: rtl/region_loader_if.sv
// Byte-stream handshake from the host command deframer into the loader.
// Signals:
//   rx_data  - frame byte
//   rx_valid - rx_data valid
//   rx_ready - byte accepted when rx_valid & rx_ready
// Modports: master = byte source (deframer), slave = byte sink (loader).
interface region_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/region_wr_demux.sv
// Fans one internal write request out to the three region RAM write ports,
// registered one stage.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   wr                - write request (enable, region, address, data)
//   regionN_wren      - one-cycle write strobe for region N
//   regionN_wraddr/   - address/data for region N; they keep the last values
//   regionN_wrdata      written to that region
module region_wr_demux
    import region_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ram_wr_t           wr,
    output logic              region0_wren,
    output logic [RAM_AW-1:0] region0_wraddr,
    output logic [RAM_DW-1:0] region0_wrdata,
    output logic              region1_wren,
    output logic [RAM_AW-1:0] region1_wraddr,
    output logic [RAM_DW-1:0] region1_wrdata,
    output logic              region2_wren,
    output logic [RAM_AW-1:0] region2_wraddr,
    output logic [RAM_DW-1:0] region2_wrdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            region0_wren   <= 1'b0;
            region0_wraddr <= '0;
            region0_wrdata <= '0;
            region1_wren   <= 1'b0;
            region1_wraddr <= '0;
            region1_wrdata <= '0;
            region2_wren   <= 1'b0;
            region2_wraddr <= '0;
            region2_wrdata <= '0;
        end else begin
            region0_wren <= wr.en && (wr.sel == REGION_INNER);
            region1_wren <= wr.en && (wr.sel == REGION_MIDDLE);
            region2_wren <= wr.en && (wr.sel == REGION_OUTER);
            if (wr.en) begin
                case (wr.sel)
                    REGION_INNER: begin
                        region0_wraddr <= wr.addr;
                        region0_wrdata <= wr.data;
                    end
                    REGION_MIDDLE: begin
                        region1_wraddr <= wr.addr;
                        region1_wrdata <= wr.data;
                    end
                    REGION_OUTER: begin
                        region2_wraddr <= wr.addr;
                        region2_wrdata <= wr.data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/region_loader.sv
// Writer side of the region-boundary RAMs read by the scan comparator.
// Parses a configuration frame
//   A5 5A SEL ST_H ST_L CN_H CN_L {D_H D_L} x CNT CHK
// and writes {2'b00, D_H, D_L} to region SEL at START + word index.
// Byte intake is held off during data bytes while cycle_enable is high, so a
// region is never modified mid-revolution.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   rx                - byte-stream handshake (slave side)
//   cycle_enable      - comparator is scanning a revolution
//   regionN_wren/     - region RAM write ports (one cycle after D_L accept)
//   wraddr/wrdata
//   busy              - frame in progress
//   frame_done        - one-cycle pulse, frame ended with good checksum
//   frame_err         - one-cycle pulse, frame ended with an error
//   err_code          - cause of the last frame_err (held)
module region_loader
    import region_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    region_loader_if.slave    rx,
    input  logic              cycle_enable,
    output logic              region0_wren,
    output logic [RAM_AW-1:0] region0_wraddr,
    output logic [RAM_DW-1:0] region0_wrdata,
    output logic              region1_wren,
    output logic [RAM_AW-1:0] region1_wraddr,
    output logic [RAM_DW-1:0] region1_wrdata,
    output logic              region2_wren,
    output logic [RAM_AW-1:0] region2_wraddr,
    output logic [RAM_DW-1:0] region2_wrdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_q, state_d;
    logic [7:0]       sel_q;
    logic [15:0]      start_q;
    logic [15:0]      cnt_q;
    logic [15:0]      widx_q;
    logic [7:0]       dh_q;
    logic [7:0]       xor_q;
    logic [TMO_W-1:0] tmo_q;
    err_code_t        err_code_q;

    logic        accept;
    logic        in_data;
    logic [15:0] cnt_full;
    logic [16:0] end_idx;
    logic        hdr_bad;
    logic        last_word;
    logic        tmo_hit;
    logic        done_d;
    logic        err_d;
    err_code_t   err_kind;
    ram_wr_t     wr;

    // Interlock: data bytes are only taken while no revolution is being scanned.
    assign in_data     = (state_q == S_D_H) || (state_q == S_D_L);
    assign rx.rx_ready = in_data ? ~cycle_enable : 1'b1;
    assign accept      = rx.rx_valid && rx.rx_ready;

    // Validation uses the count including the CN_L byte arriving this cycle;
    // the end index is 17 bits wide so START + CNT cannot wrap.
    assign cnt_full  = {cnt_q[15:8], rx.rx_data};
    assign end_idx   = {1'b0, start_q} + {1'b0, cnt_full};
    assign hdr_bad   = (sel_q > 8'd2) || (cnt_full == 16'd0) ||
                       (end_idx > 17'(NUM_POINTS));
    assign last_word = (widx_q == cnt_q - 16'd1);

    // Timeout fires on the TIMEOUT_CYC-th counted idle cycle; an accepted
    // byte in that same cycle takes precedence.
    assign tmo_hit = (state_q != S_IDLE) && !accept && !cycle_enable &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    assign busy     = (state_q != S_IDLE);
    assign err_code = err_code_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        err_kind = ERR_NONE;
        if (tmo_hit) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            err_kind = ERR_TMO;
        end else if (accept) begin
            case (state_q)
                S_IDLE: if (rx.rx_data == HDR0) state_d = S_HDR;
                S_HDR: begin
                    if (rx.rx_data == HDR1)      state_d = S_SEL;
                    else if (rx.rx_data == HDR0) state_d = S_HDR;
                    else                         state_d = S_IDLE;
                end
                S_SEL:  state_d = S_ST_H;
                S_ST_H: state_d = S_ST_L;
                S_ST_L: state_d = S_CN_H;
                S_CN_H: state_d = S_CN_L;
                S_CN_L: begin
                    if (hdr_bad) begin
                        state_d  = S_IDLE;
                        err_d    = 1'b1;
                        err_kind = ERR_HDR;
                    end else begin
                        state_d = S_D_H;
                    end
                end
                S_D_H: state_d = S_D_L;
                S_D_L: state_d = last_word ? S_CHK : S_D_H;
                S_CHK: begin
                    state_d = S_IDLE;
                    if (rx.rx_data == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        err_kind = ERR_CHK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write request issued on D_L acceptance; the demux register makes the
    // strobe visible on the following cycle.
    always_comb begin
        wr      = '0;
        wr.en   = accept && (state_q == S_D_L);
        wr.sel  = region_sel_t'(sel_q[1:0]);
        wr.addr = start_q[RAM_AW-1:0] + widx_q[RAM_AW-1:0];
        wr.data = {2'b00, dh_q, rx.rx_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            start_q    <= '0;
            cnt_q      <= '0;
            widx_q     <= '0;
            dh_q       <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (accept) begin
                case (state_q)
                    S_SEL:  sel_q         <= rx.rx_data;
                    S_ST_H: start_q[15:8] <= rx.rx_data;
                    S_ST_L: start_q[7:0]  <= rx.rx_data;
                    S_CN_H: cnt_q[15:8]   <= rx.rx_data;
                    S_CN_L: begin
                        cnt_q[7:0] <= rx.rx_data;
                        widx_q     <= '0;
                    end
                    S_D_H:  dh_q   <= rx.rx_data;
                    S_D_L:  widx_q <= widx_q + 16'd1;
                    default: ;
                endcase
            end

            if (state_q == S_IDLE) begin
                xor_q <= '0;
            end else if (accept && (state_q inside {S_SEL, S_ST_H, S_ST_L,
                                                    S_CN_H, S_CN_L, S_D_H, S_D_L})) begin
                xor_q <= xor_q ^ rx.rx_data;
            end

            // Interlock stalls hold the count rather than clearing it.
            if ((state_q == S_IDLE) || accept) tmo_q <= '0;
            else if (!cycle_enable)            tmo_q <= tmo_q + 1'b1;

            frame_done <= done_d;
            frame_err  <= err_d;
            if (err_d) err_code_q <= err_kind;
        end
    end

    region_wr_demux u_demux (
        .clk            (clk),
        .rst            (rst),
        .wr             (wr),
        .region0_wren   (region0_wren),
        .region0_wraddr (region0_wraddr),
        .region0_wrdata (region0_wrdata),
        .region1_wren   (region1_wren),
        .region1_wraddr (region1_wraddr),
        .region1_wrdata (region1_wrdata),
        .region2_wren   (region2_wren),
        .region2_wraddr (region2_wraddr),
        .region2_wrdata (region2_wrdata)
    );

endmodule

// File: tb/tb_region_loader.sv
// Directed bench for region_loader (TIMEOUT_CYC = 50). Drives frames through
// the byte handshake, logs RAM writes and status pulses on the falling edge,
// and compares them with hand-computed values.
module tb_region_loader;

    logic        clk;
    logic        rst;
    logic        cycle_enable;
    logic        region0_wren, region1_wren, region2_wren;
    logic [9:0]  region0_wraddr, region1_wraddr, region2_wraddr;
    logic [17:0] region0_wrdata, region1_wrdata, region2_wrdata;
    logic        busy, frame_done, frame_err;
    logic [1:0]  err_code;

    region_loader_if rx_if ();

    region_loader #(.TIMEOUT_CYC(50)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx_if),
        .cycle_enable   (cycle_enable),
        .region0_wren   (region0_wren),
        .region0_wraddr (region0_wraddr),
        .region0_wrdata (region0_wrdata),
        .region1_wren   (region1_wren),
        .region1_wraddr (region1_wraddr),
        .region1_wrdata (region1_wrdata),
        .region2_wren   (region2_wren),
        .region2_wraddr (region2_wraddr),
        .region2_wrdata (region2_wrdata),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .err_code       (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned region;
        logic [9:0]  addr;
        logic [17:0] data;
    } wr_rec_t;

    wr_rec_t wlog[$];
    int      n_done = 0;
    int      n_err  = 0;
    int      n_pass = 0;
    int      n_total = 0;
    logic [7:0] run_x;

    always @(negedge clk) begin
        if (region0_wren) wlog.push_back('{0, region0_wraddr, region0_wrdata});
        if (region1_wren) wlog.push_back('{1, region1_wraddr, region1_wrdata});
        if (region2_wren) wlog.push_back('{2, region2_wraddr, region2_wrdata});
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_wr(input string tag, input int idx, input int unsigned region,
                            input logic [9:0] addr, input logic [17:0] data);
        if (idx < wlog.size()) begin
            check({tag, "_region"}, wlog[idx].region, region);
            check({tag, "_addr"}, 32'(wlog[idx].addr), 32'(addr));
            check({tag, "_data"}, 32'(wlog[idx].data), 32'(data));
        end else begin
            check({tag, "_present"}, wlog.size(), idx + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte from a falling edge; wait (bounded) for rx_ready.
    task automatic send_b(input logic [7:0] b);
        int n = 0;
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        #1;
        while (!rx_if.rx_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("byte_accept", 32'(rx_if.rx_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_x(input logic [7:0] b);
        send_b(b);
        run_x ^= b;
    endtask

    task automatic begin_frame(input logic [7:0] sel, input logic [15:0] start,
                               input logic [15:0] cnt);
        send_b(8'hA5);
        send_b(8'h5A);
        run_x = 8'h00;
        send_x(sel);
        send_x(start[15:8]);
        send_x(start[7:0]);
        send_x(cnt[15:8]);
        send_x(cnt[7:0]);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_x(w[15:8]);
        send_x(w[7:0]);
    endtask

    task automatic end_frame(input logic [7:0] flip);
        send_b(run_x ^ flip);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, db, eb, stall_rdy, stall_wr, tmo_at;

        rst            = 1'b1;
        cycle_enable   = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        #1;
        check("rst_rx_ready", 32'(rx_if.rx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wren", 32'({region0_wren, region1_wren, region2_wren}), 0);
        check("rst_done_err", 32'({frame_done, frame_err}), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_wraddr1", 32'(region1_wraddr), 0);
        idle(3);
        rst = 1'b0;
        idle(2);

        // Good frame: region 1, START 0, three words including the marker.
        wb = wlog.size(); db = n_done; eb = n_err;
        begin_frame(8'd1, 16'd0, 16'd3);
        send_word(16'h0100);
        send_word(16'h0200);
        send_word(16'hFFFF);
        end_frame(8'h00);
        idle(3);
        check("good_nwr", wlog.size() - wb, 3);
        check_wr("good_w0", wb + 0, 1, 10'd0, 18'h00100);
        check_wr("good_w1", wb + 1, 1, 10'd1, 18'h00200);
        check_wr("good_w2", wb + 2, 1, 10'd2, 18'h0FFFF);
        check("good_done", n_done - db, 1);
        check("good_err", n_err - eb, 0);
        check("good_busy", 32'(busy), 0);

        // Last legal index.
        wb = wlog.size(); db = n_done;
        begin_frame(8'd2, 16'd810, 16'd1);
        send_word(16'h1234);
        end_frame(8'h00);
        idle(3);
        check("edge_nwr", wlog.size() - wb, 1);
        check_wr("edge_w0", wb, 2, 10'd810, 18'h01234);
        check("edge_done", n_done - db, 1);

        // START + CNT = 812 > 811: rejected at CN_L, body bytes swallowed.
        wb = wlog.size(); db = n_done; eb = n_err;
        begin_frame(8'd2, 16'd810, 16'd2);
        idle(2);
        check("range_err", n_err - eb, 1);
        check("range_code", 32'(err_code), 1);
        check("range_busy", 32'(busy), 0);
        send_b(8'h11);
        send_b(8'h22);
        send_b(8'h33);
        send_b(8'h44);
        send_b(8'h00);
        idle(3);
        check("range_nwr", wlog.size() - wb, 0);
        check("range_done", n_done - db, 0);
        check("range_err_once", n_err - eb, 1);
        check("range_rdy", 32'(rx_if.rx_ready), 1);

        // Bad checksum: both words still land, then ERR_CHK.
        wb = wlog.size(); db = n_done; eb = n_err;
        begin_frame(8'd0, 16'd5, 16'd2);
        send_word(16'hABCD);
        send_word(16'h0001);
        end_frame(8'h01);
        idle(3);
        check("chk_nwr", wlog.size() - wb, 2);
        check_wr("chk_w0", wb + 0, 0, 10'd5, 18'h0ABCD);
        check_wr("chk_w1", wb + 1, 0, 10'd6, 18'h00001);
        check("chk_err", n_err - eb, 1);
        check("chk_code", 32'(err_code), 2);
        check("chk_done", n_done - db, 0);

        // Interlock: cycle_enable held high for 500 cycles after the first word.
        wb = wlog.size(); db = n_done; eb = n_err;
        begin_frame(8'd1, 16'd100, 16'd3);
        send_word(16'h1111);
        cycle_enable   = 1'b1;
        rx_if.rx_data  = 8'h22;
        rx_if.rx_valid = 1'b1;
        stall_rdy = 0;
        stall_wr  = 0;
        repeat (500) begin
            @(negedge clk);
            if (rx_if.rx_ready) stall_rdy++;
            if (region0_wren || region1_wren || region2_wren) stall_wr++;
        end
        check("lock_ready_low", stall_rdy, 0);
        check("lock_no_wren", stall_wr, 0);
        check("lock_no_tmo", n_err - eb, 0);
        check("lock_nwr", wlog.size() - wb, 1);
        cycle_enable = 1'b0;
        send_word(16'h2222);
        send_word(16'h3333);
        end_frame(8'h00);
        idle(3);
        check("lock_nwr_end", wlog.size() - wb, 3);
        check_wr("lock_w0", wb + 0, 1, 10'd100, 18'h01111);
        check_wr("lock_w1", wb + 1, 1, 10'd101, 18'h02222);
        check_wr("lock_w2", wb + 2, 1, 10'd102, 18'h03333);
        check("lock_done", n_done - db, 1);

        // Timeout: stop after ST_H; frame_err appears on idle cycle 50.
        eb = n_err;
        send_b(8'hA5);
        send_b(8'h5A);
        send_b(8'h01);
        send_b(8'h00);
        tmo_at = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                tmo_at = k;
                break;
            end
        end
        check("tmo_cycle", tmo_at, 50);
        check("tmo_code", 32'(err_code), 3);
        idle(2);
        check("tmo_err", n_err - eb, 1);
        check("tmo_busy", 32'(busy), 0);
        wb = wlog.size(); db = n_done;
        begin_frame(8'd0, 16'd0, 16'd1);
        send_word(16'h0042);
        end_frame(8'h00);
        idle(3);
        check("post_tmo_nwr", wlog.size() - wb, 1);
        check_wr("post_tmo_w0", wb, 0, 10'd0, 18'h00042);
        check("post_tmo_done", n_done - db, 1);

        // Resync: A5 A5 5A followed by a valid body.
        wb = wlog.size(); db = n_done;
        send_b(8'hA5);
        begin_frame(8'd2, 16'd3, 16'd2);
        send_word(16'h00FF);
        send_word(16'h8000);
        end_frame(8'h00);
        idle(3);
        check("resync_nwr", wlog.size() - wb, 2);
        check_wr("resync_w0", wb + 0, 2, 10'd3, 18'h000FF);
        check_wr("resync_w1", wb + 1, 2, 10'd4, 18'h08000);
        check("resync_done", n_done - db, 1);

        // Reset in the middle of the data phase.
        wb = wlog.size(); db = n_done; eb = n_err;
        begin_frame(8'd1, 16'd10, 16'd3);
        send_word(16'h5555);
        send_b(8'h66);
        rst = 1'b1;
        #1;
        check("mid_rst_wren", 32'({region0_wren, region1_wren, region2_wren}), 0);
        check("mid_rst_ready", 32'(rx_if.rx_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        idle(2);
        rst = 1'b0;
        idle(3);
        check("mid_rst_nwr", wlog.size() - wb, 1);
        check_wr("mid_rst_w0", wb, 1, 10'd10, 18'h05555);
        check("mid_rst_status", (n_done - db) + (n_err - eb), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/region_loader.md
Name: region_loader

Overview:
- Writer side of the region-boundary RAMs consumed by the scan comparator.
- Parses a byte-stream configuration frame from the host command path (UART/UDP byte deframer) and writes 16-bit boundary distances into one of three region RAMs: 0 = inner, 1 = middle, 2 = outer. Each RAM holds 811 points, 18-bit words.
- Withholds writes while a scan cycle is active, so the comparator never reads a half-updated region during a revolution.

Parameters:
- NUM_POINTS, 811, points per region; legal indices 0..NUM_POINTS-1.
- TIMEOUT_CYC, 100000, maximum idle cycles between accepted bytes inside a frame.
- HDR0, 8'hA5, first sync byte.
- HDR1, 8'h5A, second sync byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  frame byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready.
- cycle_enable  in  1  high while the comparator scans a revolution.
- region0_wren / region1_wren / region2_wren  out  1 each  RAM write strobe.
- region0_wraddr / region1_wraddr / region2_wraddr  out  10 each  write address.
- region0_wrdata / region1_wrdata / region2_wrdata  out  18 each  write data.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse: frame ended with good checksum.
- frame_err  out  1  one-cycle pulse: frame ended with an error.
- err_code  out  2  cause of last error, held until the next frame_err: 1 = bad header field, 2 = checksum, 3 = timeout.

Behaviour:
- Reset values: all outputs 0 except rx_ready = 1; FSM in IDLE.
- Reset asserted mid-frame aborts the frame; RAM words already written stay written.
- Frame format, in order:
  - HDR0, HDR1.
  - SEL: region 0..2.
  - START_H, START_L: 16-bit start index.
  - CNT_H, CNT_L: 16-bit count.
  - CNT x (D_H, D_L): big-endian 16-bit boundary values.
  - CHK = XOR of all bytes from SEL through the last D_L.
- States: IDLE, HDR, SEL, ST_H, ST_L, CN_H, CN_L, D_H, D_L, CHK.
- IDLE→HDR on HDR0. HDR→SEL on HDR1; any other byte returns to IDLE, but if that byte equals HDR0 the FSM stays in HDR.
- SEL through CN_L: advance one state per accepted byte.
- Validation on leaving CN_L. The frame is rejected if any of:
  - SEL > 2;
  - CNT == 0;
  - START + CNT > NUM_POINTS (17-bit compare, no wrap).
- On rejection: frame_err, err_code = 1, back to IDLE. Remaining frame bytes are swallowed as non-header bytes; rx_ready stays 1.
- D_H→D_L→D_H loops for CNT words, then CHK.
- Write timing: the cycle after a D_L byte is accepted, the selected regionN_wren = 1 for exactly one cycle.
  - wraddr = START + word index (index starts at 0, increments after each write).
  - wrdata = {2'b00, D_H, D_L}.
  - Unselected regions see wren = 0. wraddr/wrdata remain driven with the last values.
- 16'hFFFF is written verbatim; it is the "no boundary" marker the comparator ignores.
- Scan interlock: in D_H and D_L, rx_ready = ~cycle_enable. In all other states rx_ready = 1.
  - If cycle_enable rises in the same cycle a D_L byte is accepted, that write still issues.
  - No write strobe is ever asserted in a cycle where cycle_enable was sampled high and no byte was accepted.
- CHK state:
  - Byte equals the running XOR → frame_done.
  - Otherwise → frame_err, err_code = 2.
  - Either way, back to IDLE.
  - Words already written are not rolled back; the host resends.
- Timeout: a counter clears on every accepted byte and counts only in non-IDLE states while cycle_enable = 0.
  - Stalls due to the interlock do not time out.
  - Reaching TIMEOUT_CYC → frame_err, err_code = 3, back to IDLE.
- Simultaneous timeout and byte acceptance: the byte wins and the counter clears.
- Running XOR: clears in IDLE; updates on each accepted byte from SEL through D_L.

Decomposition:
- Shared package region_pkg:
  - NUM_POINTS, HDR0, HDR1, region index encodings.
  - err_code encodings (ERR_NONE = 0, ERR_HDR = 1, ERR_CHK = 2, ERR_TMO = 3).
  - RAM data width 18, RAM address width 10.
- One sub-module, region_wr_demux: takes sel, wren, wraddr, wrdata and fans out to the three RAM ports, registered one stage. The FSM therefore issues the write internally on D_L acceptance.

Test Plan:
- Good frame: SEL = 1, START = 0, CNT = 3, data 0x0100, 0x0200, 0xFFFF, correct CHK → region1_wren pulses at addresses 0, 1, 2 with 18'h00100, 18'h00200, 18'h0FFFF; frame_done = 1; regions 0 and 2 never written.
- Boundary: SEL = 2, START = 810, CNT = 1 → single write at address 810, frame_done. START = 810, CNT = 2 → no writes, frame_err, err_code = 1.
- Bad CHK (good CHK ^ 0x01) with SEL = 0, CNT = 2 → two writes occur, then frame_err, err_code = 2.
- Interlock: raise cycle_enable after the first D_L and hold it for 500 cycles while rx_valid = 1 → rx_ready = 0 and no wren for those 500 cycles, no timeout. Drop cycle_enable → remaining words are written, frame_done.
- Timeout with TIMEOUT_CYC = 50: stop bytes after ST_H with cycle_enable = 0 → frame_err, err_code = 3 on cycle 50. The next good frame is processed normally.
- Resync: stream A5 A5 5A followed by a valid frame body → frame accepted. Assert rst mid-data → all strobes 0, rx_ready = 1, busy = 0.
